// File: rtl/get_d.sv
// get_d: signed-digit selection for E-mode/L-mode CORDIC-style iterations.
// Define GET_D_BYPASS_EN to make the digit outputs purely combinational.
module get_d #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                mode,
    input  logic signed [W-1:0] u,
    input  logic signed [W-1:0] v,
    output logic        [1:0]   d_x,
    output logic        [1:0]   d_y
);
    localparam logic signed [W-1:0] HALF      = W'(2 ** (W - 5));
    localparam logic signed [W-1:0] FIVE8     = W'(5 * 2 ** (W - 7));
    localparam logic signed [W-1:0] NEG_HALF  = -HALF;
    localparam logic signed [W-1:0] NEG_FIVE8 = -FIVE8;
    localparam logic [1:0] POS = 2'b01;
    localparam logic [1:0] NEG = 2'b11;
    localparam logic [1:0] ZER = 2'b00;

    logic [1:0] d_x_d, d_y_d;

    // E-mode has an asymmetric lower threshold on u; L-mode flips the digit sign
    always_comb begin
        d_x_d = ZER;
        d_y_d = ZER;
        if (mode) begin
            d_x_d = (u <= NEG_HALF) ? POS : (u >= HALF) ? NEG : ZER;
            d_y_d = (v <= NEG_HALF) ? POS : (v >= HALF) ? NEG : ZER;
        end else begin
            d_x_d = (u <= NEG_FIVE8) ? NEG : (u >= HALF) ? POS : ZER;
            d_y_d = (v <= NEG_HALF)  ? NEG : (v >= HALF) ? POS : ZER;
        end
    end

`ifdef GET_D_BYPASS_EN
    logic unused;
    assign unused = ^{clk, rst, ena};
    assign d_x = d_x_d;
    assign d_y = d_y_d;
`else
    logic [1:0] d_x_q, d_y_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_x_q <= ZER;
            d_y_q <= ZER;
        end else if (ena) begin
            d_x_q <= d_x_d;
            d_y_q <= d_y_d;
        end
    end

    assign d_x = d_x_q;
    assign d_y = d_y_q;
`endif
endmodule

// File: tb/tb_get_d.sv
// tb_get_d: directed and random scoreboard bench for get_d (W=8).
module tb_get_d;
    logic clk = 1'b0;
    logic rst, ena, mode;
    logic signed [7:0] u, v;
    logic [1:0] d_x, d_y;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      tag;
        logic [1:0] ex;
        logic [1:0] ey;
    } exp_t;
    exp_t sb[$];

    get_d #(.W(8)) dut (
        .clk(clk), .rst(rst), .ena(ena), .mode(mode),
        .u(u), .v(v), .d_x(d_x), .d_y(d_y)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model(input logic m, input int a, input int b);
        logic [1:0] x, y;
        if (!m) begin
            x = (a <= -10) ? 2'b11 : (a >= 8) ? 2'b01 : 2'b00;
            y = (b <= -8)  ? 2'b11 : (b >= 8) ? 2'b01 : 2'b00;
        end else begin
            x = (a <= -8) ? 2'b01 : (a >= 8) ? 2'b11 : 2'b00;
            y = (b <= -8) ? 2'b01 : (b >= 8) ? 2'b11 : 2'b00;
        end
        return {x, y};
    endfunction

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert ({d_x, d_y} === {e.ex, e.ey}) else begin
            errors++;
            $error("FAIL %s: got d_x=%b d_y=%b expected d_x=%b d_y=%b", e.tag, d_x, d_y, e.ex, e.ey);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic en, input logic m,
                        input int a, input int b, input logic [1:0] ex, input logic [1:0] ey);
        @(negedge clk);
        rst = r; ena = en; mode = m; u = 8'(a); v = 8'(b);
        sb.push_back('{tag, ex, ey});
`ifdef GET_D_BYPASS_EN
        #1;
`else
        @(posedge clk);
        #1;
`endif
        check_out();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; mode = 1'b0; u = '0; v = '0;
`ifdef GET_D_BYPASS_EN
        step("byp_e", 1, 0, 0, 8, -10, 2'b01, 2'b11);
        step("byp_l", 1, 1, 1, 8, -10, 2'b11, 2'b01);
        step("byp_ext_e", 0, 0, 0, -128, 127, 2'b11, 2'b01);
        step("byp_ext_l", 0, 0, 1, -128, 127, 2'b01, 2'b11);
`else
        step("rst_ena0", 1, 0, 0, -128, 127, 2'b00, 2'b00);
        step("rst_ena1", 1, 1, 0, 8, 8, 2'b00, 2'b00);
        step("e_m10_8", 0, 1, 0, -10, 8, 2'b11, 2'b01);
        step("e_m9_7", 0, 1, 0, -9, 7, 2'b00, 2'b00);
        step("e_8_m8", 0, 1, 0, 8, -8, 2'b01, 2'b11);
        step("e_7_m7", 0, 1, 0, 7, -7, 2'b00, 2'b00);
        step("l_8_m8", 0, 1, 1, 8, -8, 2'b11, 2'b01);
        step("l_m8_8", 0, 1, 1, -8, 8, 2'b01, 2'b11);
        step("l_m7_7", 0, 1, 1, -7, 7, 2'b00, 2'b00);
        step("ext_e", 0, 1, 0, -128, 127, 2'b11, 2'b01);
        step("ext_l", 0, 1, 1, -128, 127, 2'b01, 2'b11);
        step("ext_e2", 0, 1, 0, 127, -128, 2'b01, 2'b11);
        step("load", 0, 1, 1, -8, 8, 2'b01, 2'b11);
        for (int i = 0; i < 5; i++) step("hold", 0, 0, 1, 0, 0, 2'b01, 2'b11);
        step("resume", 0, 1, 1, 0, 0, 2'b00, 2'b00);
        step("pre_rst", 0, 1, 0, 8, 8, 2'b01, 2'b01);
        step("mid_rst", 1, 1, 0, 8, 8, 2'b00, 2'b00);
        step("post_rst", 0, 1, 0, -10, -8, 2'b11, 2'b11);
        step("rst_hold", 0, 0, 0, 20, 20, 2'b11, 2'b11);
`endif
        for (int i = 0; i < 40; i++) begin
            int a, b;
            logic m;
            logic [3:0] e;
            a = int'($urandom_range(0, 255)) - 128;
            b = int'($urandom_range(0, 255)) - 128;
            m = 1'($urandom_range(0, 1));
            e = model(m, a, b);
            step("rand", 0, 1, m, a, b, e[3:2], e[1:0]);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/get_d.md
GET_D -- requirements
Module: get_d

Interface
REQ-001 Parameter W, default 8, meaning width of u and v in bits; legal range W >= 7.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 ena  input  1  update enable for the output registers.
REQ-005 mode  input  1  0 = E-mode (exponential), 1 = L-mode (logarithm).
REQ-006 u  input  W  signed two's complement real-part residual, fixed point with F = W-4 fractional bits.
REQ-007 v  input  W  signed two's complement imaginary-part residual, same format as u.
REQ-008 d_x  output  2  signed digit for the real part.
REQ-009 d_y  output  2  signed digit for the imaginary part.

Function
REQ-010 Digit encoding SHALL be 2'b11 = -1, 2'b00 = 0, 2'b01 = +1; 2'b10 SHALL never be driven.
REQ-011 Constants SHALL be HALF = 2^(W-5) (value 1/2) and FIVE8 = 5*2^(W-7) (value 5/8); for W=8 these are HALF=8 and FIVE8=10.
REQ-012 E-mode d_x SHALL be -1 if u <= -FIVE8, +1 if u >= HALF, and 0 otherwise.
REQ-013 E-mode d_y SHALL be -1 if v <= -HALF, +1 if v >= HALF, and 0 otherwise.
REQ-014 L-mode d_x SHALL be +1 if u <= -HALF, -1 if u >= HALF, and 0 otherwise.
REQ-015 L-mode d_y SHALL be +1 if v <= -HALF, -1 if v >= HALF, and 0 otherwise.
REQ-016 All comparisons SHALL be signed over the full W bits, with no truncation error at the thresholds.
REQ-017 Extreme values (-2^(W-1) and 2^(W-1)-1) SHALL follow the same rules without overflow.
REQ-018 d_x and d_y SHALL be registered, with latency 1 cycle from sampled inputs to outputs.
REQ-019 When ena=1 and rst=0, the outputs SHALL load the digits computed from the current mode, u and v.
REQ-020 When ena=0 and rst=0, the outputs SHALL hold their values.
REQ-021 A mode change SHALL take effect on the first enabled edge after the change, with no extra delay.

Reset
REQ-022 With rst=1 at a rising edge, d_x and d_y SHALL become 2'b00 regardless of ena.
REQ-023 rst SHALL have priority over ena.
REQ-024 After rst is released, the first enabled edge SHALL produce valid digits.
REQ-025 Asserting rst mid-operation SHALL discard the pending digits.

Configuration
REQ-026 Macro GET_D_BYPASS_EN SHALL control output registering.
REQ-027 When GET_D_BYPASS_EN is defined, d_x and d_y SHALL be purely combinational functions of mode, u and v with zero latency.
REQ-028 When GET_D_BYPASS_EN is defined, clk, rst and ena SHALL be accepted but have no effect.
REQ-029 When GET_D_BYPASS_EN is not defined (default), the registered behaviour of REQ-018 through REQ-025 SHALL apply.

Verification (W=8, registered build unless noted)
REQ-030 Reset: rst=1 for 1 edge with any inputs -> d_x=00 and d_y=00 after that edge; ena=1 with rst=1 still gives 00.
REQ-031 E-mode thresholds: drive mode=0, ena=1 with each (u, v) pair below; one cycle later:
  - u=-10, v=8 -> d_x=-1, d_y=+1;
  - u=-9, v=7 -> d_x=0, d_y=0;
  - u=8, v=-8 -> d_x=+1, d_y=-1;
  - u=7, v=-7 -> d_x=0, d_y=0.
REQ-032 L-mode thresholds: drive mode=1, ena=1 with each (u, v) pair below; one cycle later:
  - u=8, v=-8 -> d_x=-1, d_y=+1;
  - u=-8, v=8 -> d_x=+1, d_y=-1;
  - u=-7, v=7 -> d_x=0, d_y=0.
REQ-033 Extremes: u=-128, v=127 -> E-mode gives (-1, +1) and L-mode gives (+1, -1).
REQ-034 Hold: after loading (+1, -1), set ena=0 and apply u=0, v=0 for 5 cycles -> outputs stay (+1, -1); restoring ena=1 gives (0, 0) one cycle later.
REQ-035 Bypass build (GET_D_BYPASS_EN defined): mode=0, u=8, v=-10 -> d_x=+1 and d_y=-1 in the same cycle, with no clock edge needed.
